// File: rtl/beeb_bus_pkg.sv
// Shared types and constants for the host bus bridge: FSM states, idle bus
// pattern and the posted-write entry layout.
package beeb_bus_pkg;

    localparam int unsigned BUS_ADDR_W = 16;
    localparam int unsigned BUS_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FIFO_CYC  = 2'd1,
        STALL_CYC = 2'd2
    } bridge_state_e;

    // Idle host cycle: address and data lines all-ones, read strobe
    localparam logic IDLE_ADDR_BIT = 1'b1;
    localparam logic IDLE_DATA_BIT = 1'b1;
    localparam logic IDLE_WE       = 1'b0;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] data;
    } wfifo_entry_t;

endpackage

// File: rtl/beeb_wr_fifo.sv
// Posted-write FIFO; extra pointer bit distinguishes full from empty and the
// pointers wrap by natural overflow.
module beeb_wr_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (level == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO may still accept when the head leaves in the same clock
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/beeb_bus_bridge.sv
// Fast-clock bridge to the host bus: Phi0 resynchronisation, host cycle
// sequencing with a posted-write FIFO, and the latch-write slowdown counter.
module beeb_bus_bridge
    import beeb_bus_pkg::*;
#(
    parameter int unsigned        ADDR_W      = 16,
    parameter int unsigned        DATA_W      = 8,
    parameter int unsigned        NPHI0_REGS  = 5,
    parameter int unsigned        PHIOUT_TAP  = 1,
    parameter int unsigned        WFIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  SLOW_ADDR   = ADDR_W'(16'hFE40),
    parameter int unsigned        SLOW_LONG   = 15,
    parameter int unsigned        SLOW_SHORT  = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           phi_in,
    output logic                           phi1_out,
    output logic                           phi2_out,
    input  logic                           req_valid,
    input  logic                           req_we,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [DATA_W-1:0]              req_wdata,
    output logic                           req_ready,
    output logic [DATA_W-1:0]              rdata,
    output logic [ADDR_W-1:0]              bus_addr,
    output logic                           bus_we,
    output logic [DATA_W-1:0]              bus_dout,
    input  logic [DATA_W-1:0]              bus_din,
    output logic                           bus_oe,
    output logic                           slow_active,
    output logic [$clog2(WFIFO_DEPTH):0]   wfifo_level
);

    localparam int unsigned LVL_W    = $clog2(WFIFO_DEPTH) + 1;
    localparam int unsigned SLOW_MAX = (SLOW_LONG > SLOW_SHORT) ? SLOW_LONG : SLOW_SHORT;
    localparam int unsigned SLOW_W   = $clog2(SLOW_MAX + 1);
    localparam int unsigned ENTRY_W  = ADDR_W + DATA_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [NPHI0_REGS-1:0] phi_r;
    logic                  sample_tick;
    logic                  cycle_end;
    logic                  cycle_start;
    logic [DATA_W-1:0]     rdata_r;

    bridge_state_e         state_q, state_d;
    logic [ADDR_W-1:0]     addr_d;
    logic                  we_d;
    logic [DATA_W-1:0]     dout_d;
    logic [SLOW_W-1:0]     slow_q, slow_d;

    logic                  postable;
    logic                  stall_req;
    logic                  stall_done;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LVL_W-1:0]      fifo_level;
    entry_t                fifo_wdata;
    entry_t                fifo_head;

    // Phi0 synchroniser / delay line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phi_r       <= '0;
            cycle_start <= 1'b0;
            rdata_r     <= '0;
        end else begin
            phi_r       <= {phi_r[NPHI0_REGS-2:0], phi_in};
            cycle_start <= cycle_end;
            if (sample_tick) rdata_r <= bus_din;
        end
    end

    assign phi2_out    = phi_r[PHIOUT_TAP];
    assign phi1_out    = ~phi_r[PHIOUT_TAP];
    assign sample_tick = phi_r[PHIOUT_TAP+1] & ~phi_r[PHIOUT_TAP];
    assign cycle_end   = phi_r[NPHI0_REGS-1] & ~phi_r[NPHI0_REGS-2];

    assign postable  = req_valid && req_we && (req_addr != SLOW_ADDR);
    assign stall_req = req_valid && !postable;
    assign fifo_push = postable && (!fifo_full || fifo_pop);
    assign req_ready = !reset && (fifo_push || stall_done);

    assign fifo_wdata.addr = req_addr;
    assign fifo_wdata.data = req_wdata;

    beeb_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (WFIFO_DEPTH)
    ) u_wr_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Host cycle sequencing and slowdown counter next state
    always_comb begin
        state_d    = state_q;
        addr_d     = bus_addr;
        we_d       = bus_we;
        dout_d     = bus_dout;
        slow_d     = slow_q;
        fifo_pop   = 1'b0;
        stall_done = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cycle_start) begin
                    if (!fifo_empty) begin
                        addr_d  = fifo_head.addr;
                        we_d    = 1'b1;
                        dout_d  = fifo_head.data;
                        state_d = FIFO_CYC;
                    end else if (stall_req) begin
                        addr_d  = req_addr;
                        we_d    = req_we;
                        dout_d  = req_we ? req_wdata : {DATA_W{IDLE_DATA_BIT}};
                        state_d = STALL_CYC;
                    end else begin
                        addr_d  = {ADDR_W{IDLE_ADDR_BIT}};
                        we_d    = IDLE_WE;
                        dout_d  = {DATA_W{IDLE_DATA_BIT}};
                    end
                end
            end
            FIFO_CYC: begin
                if (cycle_end) begin
                    fifo_pop = 1'b1;
                    state_d  = IDLE;
                end
            end
            STALL_CYC: begin
                if (cycle_end) begin
                    stall_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cycle_end) begin
            if (stall_done && bus_we && (bus_addr == SLOW_ADDR)) begin
                slow_d = (bus_dout[2:0] == 3'b000) ? SLOW_W'(SLOW_LONG) : SLOW_W'(SLOW_SHORT);
            end else if (slow_q != '0) begin
                slow_d = slow_q - SLOW_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            bus_addr <= {ADDR_W{IDLE_ADDR_BIT}};
            bus_we   <= IDLE_WE;
            bus_dout <= {DATA_W{IDLE_DATA_BIT}};
            slow_q   <= '0;
        end else begin
            state_q  <= state_d;
            bus_addr <= addr_d;
            bus_we   <= we_d;
            bus_dout <= dout_d;
            slow_q   <= slow_d;
        end
    end

    assign rdata       = rdata_r;
    assign bus_oe      = bus_we & phi_in;
    assign slow_active = (slow_q != '0);
    assign wfifo_level = fifo_level;

    // The core must keep a stalled access asserted until it completes
    assert property (@(posedge clock) disable iff (reset) (state_q == STALL_CYC) |-> req_valid)
        else $error("req_valid dropped during a stalled host access");

endmodule

// File: tb/tb_beeb_bus_bridge.sv
// Randomised bench for beeb_bus_bridge against a host-cycle-level model of
// posted writes, stalled accesses and the slowdown counter.
module tb_beeb_bus_bridge;
    import beeb_bus_pkg::*;

    localparam int unsigned DEPTH     = 4;
    localparam logic [15:0] SLOW_ADDR = 16'hFE40;

    logic        clock = 1'b0;
    logic        reset;
    logic        phi_in;
    logic        phi1_out, phi2_out;
    logic        req_valid, req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_ready;
    logic [7:0]  rdata;
    logic [15:0] bus_addr;
    logic        bus_we;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din;
    logic        bus_oe;
    logic        slow_active;
    logic [2:0]  wfifo_level;

    beeb_bus_bridge dut (
        .clock       (clock),
        .reset       (reset),
        .phi_in      (phi_in),
        .phi1_out    (phi1_out),
        .phi2_out    (phi2_out),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rdata       (rdata),
        .bus_addr    (bus_addr),
        .bus_we      (bus_we),
        .bus_dout    (bus_dout),
        .bus_din     (bus_din),
        .bus_oe      (bus_oe),
        .slow_active (slow_active),
        .wfifo_level (wfifo_level)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } op_t;

    typedef enum int {HOST_IDLE, HOST_POSTED, HOST_STALL} host_e;

    op_t          ops[$];
    wfifo_entry_t posted[$];
    bit           phist[$];
    host_e        occ;
    logic [15:0]  m_addr;
    logic         m_we;
    logic [7:0]   m_dout;
    logic [7:0]   m_rdata;
    int           m_slow;
    bit           prev_ce;
    bit           last_ready;
    bit           hold_low;
    bit           gaps;
    int           phase_left;
    int           n_checks;
    int           n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Phi0 level k fast clocks ago; before reset release it reads low
    function automatic bit hv(input int k);
        if (k >= phist.size()) return 1'b0;
        return phist[phist.size() - 1 - k];
    endfunction

    function automatic op_t mk(input logic we, input logic [15:0] a, input logic [7:0] d);
        op_t o;
        o.we = we; o.addr = a; o.data = d;
        return o;
    endfunction

    task automatic model_reset();
        posted.delete();
        phist.delete();
        occ        = HOST_IDLE;
        m_addr     = 16'hFFFF;
        m_we       = 1'b0;
        m_dout     = 8'hFF;
        m_rdata    = 8'h00;
        m_slow     = 0;
        prev_ce    = 1'b0;
        last_ready = 1'b0;
    endtask

    task automatic drive_phi();
        if (hold_low) begin
            phi_in = 1'b0;
            return;
        end
        if (phase_left == 0) begin
            phi_in = ~phi_in;
            if (phi_in) bus_din = 8'($urandom);
            phase_left = $urandom_range(4, 9);
        end
        phase_left--;
    endtask

    task automatic drive_req();
        op_t o;
        if (last_ready) req_valid = 1'b0;
        if (!req_valid && ops.size() != 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
            o         = ops.pop_front();
            req_valid = 1'b1;
            req_we    = o.we;
            req_addr  = o.addr;
            req_wdata = o.data;
        end
    endtask

    // One fast clock: predict, sample at the falling edge, advance the model
    task automatic step();
        bit ce, cs, smp, postable, exp_ready;
        wfifo_entry_t e;
        phist.push_back(phi_in);
        if (phist.size() > 16) void'(phist.pop_front());
        ce       = hv(5) && !hv(4);
        cs       = prev_ce;
        smp      = hv(3) && !hv(2);
        postable = req_valid && req_we && (req_addr != SLOW_ADDR);
        if (postable) exp_ready = (posted.size() < DEPTH) || (occ == HOST_POSTED && ce);
        else          exp_ready = req_valid && (occ == HOST_STALL) && ce;

        @(negedge clock);
        check("req_ready",   32'(req_ready),   32'(exp_ready));
        check("bus_addr",    32'(bus_addr),    32'(m_addr));
        check("bus_we",      32'(bus_we),      32'(m_we));
        if (m_we) check("bus_dout", 32'(bus_dout), 32'(m_dout));
        check("bus_oe",      32'(bus_oe),      32'(m_we & phi_in));
        check("wfifo_level", 32'(wfifo_level), 32'(posted.size()));
        check("slow_active", 32'(slow_active), 32'(m_slow != 0));
        check("phi2_out",    32'(phi2_out),    32'(hv(2)));
        check("phi1_out",    32'(phi1_out),    32'(!hv(2)));
        if (exp_ready && req_valid && !req_we) check("rdata", 32'(rdata), 32'(m_rdata));

        last_ready = exp_ready;
        if (ce) begin
            if (occ == HOST_STALL && m_we && m_addr == SLOW_ADDR)
                m_slow = (m_dout[2:0] == 3'd0) ? 15 : 1;
            else if (m_slow > 0)
                m_slow--;
            if (occ == HOST_POSTED) void'(posted.pop_front());
            occ = HOST_IDLE;
        end
        if (cs && occ == HOST_IDLE) begin
            if (posted.size() != 0) begin
                occ = HOST_POSTED; m_addr = posted[0].addr; m_we = 1'b1; m_dout = posted[0].data;
            end else if (req_valid && !postable) begin
                occ = HOST_STALL; m_addr = req_addr; m_we = req_we; m_dout = req_wdata;
            end else begin
                m_addr = 16'hFFFF; m_we = 1'b0; m_dout = 8'hFF;
            end
        end
        if (exp_ready && postable) begin
            e.addr = req_addr;
            e.data = req_wdata;
            posted.push_back(e);
        end
        if (smp) m_rdata = bus_din;
        prev_ce = ce;
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive_phi();
            drive_req();
            step();
        end
    endtask

    task automatic release_reset();
        phi_in     = 1'b0;
        req_valid  = 1'b0;
        reset      = 1'b0;
        phase_left = 3;
        model_reset();
    endtask

    initial begin
        int lv;
        logic [7:0] d;
        n_checks  = 0;
        n_errors  = 0;
        hold_low  = 1'b0;
        gaps      = 1'b0;
        reset     = 1'b1;
        phi_in    = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 8'h00;
        bus_din   = 8'h5C;
        repeat (3) @(posedge clock);
        #1;
        check("rst_bus_addr", 32'(bus_addr),    32'h0000FFFF);
        check("rst_bus_we",   32'(bus_we),      32'h0);
        check("rst_bus_dout", 32'(bus_dout),    32'h000000FF);
        check("rst_ready",    32'(req_ready),   32'h0);
        check("rst_rdata",    32'(rdata),       32'h0);
        check("rst_level",    32'(wfifo_level), 32'h0);
        check("rst_slow",     32'(slow_active), 32'h0);
        check("rst_phi2",     32'(phi2_out),    32'h0);
        check("rst_phi1",     32'(phi1_out),    32'h1);
        release_reset();

        // Back-to-back posted writes, then FIFO overflow
        ops.push_back(mk(1'b1, 16'hFE60, 8'h11));
        ops.push_back(mk(1'b1, 16'hFE61, 8'h22));
        ops.push_back(mk(1'b1, 16'hFE62, 8'h33));
        run(120);
        for (int i = 0; i < 5; i++) ops.push_back(mk(1'b1, 16'hFE70 + 16'(i), 8'(8'hA0 + i)));
        run(200);
        // Ordering of a read behind a posted write
        ops.push_back(mk(1'b1, 16'hFE61, 8'hAA));
        ops.push_back(mk(1'b0, 16'hFE41, 8'h00));
        run(120);
        // Slowdown long reload, then short reload
        ops.push_back(mk(1'b1, SLOW_ADDR, 8'h00));
        run(60);
        ops.push_back(mk(1'b1, SLOW_ADDR, 8'h0B));
        run(200);

        // Random traffic
        gaps = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int r = $urandom_range(0, 9);
            d = 8'($urandom);
            if (r < 5)      ops.push_back(mk(1'b1, 16'hFE60 + 16'($urandom_range(0, 31)), d));
            else if (r < 8) ops.push_back(mk(1'b0, 16'($urandom), d));
            else begin
                if ($urandom_range(0, 1) == 0) d[2:0] = 3'd0;
                ops.push_back(mk(1'b1, SLOW_ADDR, d));
            end
        end
        run(4000);
        gaps = 1'b0;
        ops.delete();
        run(200);

        // Phi0 stuck low: queued writes and a read must wait
        for (int i = 0; i < 4; i++) ops.push_back(mk(1'b1, 16'hFE50 + 16'(i), 8'(i)));
        ops.push_back(mk(1'b0, 16'hFE42, 8'h00));
        hold_low = 1'b1;
        run(12);
        lv = posted.size();
        run(60);
        check("hold_level", 32'(wfifo_level), 32'(lv));
        hold_low = 1'b0;
        run(300);

        // Reset in the middle of a posted host cycle
        for (int i = 0; i < 4; i++) ops.push_back(mk(1'b1, 16'hFE68 + 16'(i), 8'(8'h40 + i)));
        for (int i = 0; i < 400 && occ != HOST_POSTED; i++) run(1);
        check("reach_fifo_cyc", 32'(occ), 32'(HOST_POSTED));
        reset = 1'b1;
        #1;
        check("mid_rst_bus_addr", 32'(bus_addr),    32'h0000FFFF);
        check("mid_rst_bus_we",   32'(bus_we),      32'h0);
        check("mid_rst_level",    32'(wfifo_level), 32'h0);
        check("mid_rst_phi2",     32'(phi2_out),    32'h0);
        check("mid_rst_ready",    32'(req_ready),   32'h0);
        ops.delete();
        req_valid = 1'b0;
        phi_in    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        release_reset();
        ops.push_back(mk(1'b1, 16'hFE63, 8'h5A));
        ops.push_back(mk(1'b0, 16'hFE41, 8'h00));
        run(150);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
